// File: rtl/armleocpu_store_sequencer_pkg.sv
// Shared store-type encodings, sequencer state encodings and reject-cause bit
// positions for the store sequencer and its data generator.
package armleocpu_store_sequencer_pkg;

  localparam logic [2:0] STORE_BYTE = 3'b000;
  localparam logic [2:0] STORE_HALF = 3'b001;
  localparam logic [2:0] STORE_WORD = 3'b010;

  localparam logic [1:0] SEQ_IDLE  = 2'd0;
  localparam logic [1:0] SEQ_ISSUE = 2'd1;
  localparam logic [1:0] SEQ_WAIT  = 2'd2;

  localparam int REJ_MISALIGNED   = 0;
  localparam int REJ_UNKNOWN_TYPE = 1;

endpackage

// File: rtl/armleocpu_store_sequencer_if.sv
// Bundle of the execute-side request channel, reject/error reports and the
// data-bus write channel seen by the store sequencer.
interface armleocpu_store_sequencer_if #(
  parameter int ADDR_W = 32
) ();

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; the initiator holds valid and payload stable until that edge and
  // ready never depends on valid. Responses and the rej/err reports are
  // single-cycle pulses with no back-pressure.
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [2:0]        req_type;
  logic [31:0]       req_data;

  logic              rej_valid;
  logic [1:0]        rej_cause;

  logic              dbus_valid;
  logic              dbus_ready;
  logic [ADDR_W-1:0] dbus_addr;
  logic [31:0]       dbus_wdata;
  logic [3:0]        dbus_wmask;
  logic              dbus_resp_valid;
  logic              dbus_resp_error;

  logic              err_valid;
  logic [ADDR_W-1:0] err_addr;
  logic              empty;
  logic [1:0]        dbg_state;

  modport slave (
    input  req_valid, req_addr, req_type, req_data,
    input  dbus_ready, dbus_resp_valid, dbus_resp_error,
    output req_ready, rej_valid, rej_cause,
    output dbus_valid, dbus_addr, dbus_wdata, dbus_wmask,
    output err_valid, err_addr, empty, dbg_state
  );

  modport master (
    output req_valid, req_addr, req_type, req_data,
    output dbus_ready, dbus_resp_valid, dbus_resp_error,
    input  req_ready, rej_valid, rej_cause,
    input  dbus_valid, dbus_addr, dbus_wdata, dbus_wmask,
    input  err_valid, err_addr, empty, dbg_state
  );

endinterface

// File: rtl/armleocpu_storegen.sv
// Store data generator: shifts store data into its byte lanes, builds the byte
// mask and flags misaligned or unknown-type stores.
module armleocpu_storegen
  import armleocpu_store_sequencer_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  st_type,
  input  logic [31:0] st_data,
  output logic [31:0] wdata,
  output logic [3:0]  wmask,
  output logic [1:0]  fault
);

  logic [4:0] shamt;
  assign shamt = {addr_lo, 3'b000};

  always_comb begin
    wdata = 32'd0;
    wmask = 4'd0;
    fault = 2'b00;
    case (st_type)
      STORE_BYTE: begin
        wdata = {24'd0, st_data[7:0]} << shamt;
        wmask = 4'b0001 << addr_lo;
      end
      STORE_HALF: begin
        wdata = {16'd0, st_data[15:0]} << shamt;
        wmask = 4'b0011 << addr_lo;
        fault[REJ_MISALIGNED] = addr_lo[0];
      end
      STORE_WORD: begin
        wdata = st_data;
        wmask = 4'b1111;
        fault[REJ_MISALIGNED] = |addr_lo;
      end
      // Unknown types report only the type fault; alignment is meaningless.
      default: fault[REJ_UNKNOWN_TYPE] = 1'b1;
    endcase
  end

endmodule

// File: rtl/armleocpu_store_sequencer.sv
// Store sequencer: buffers formatted stores in a small FIFO and issues them to
// the data bus one outstanding write at a time, reporting rejects and bus errors.
module armleocpu_store_sequencer
  import armleocpu_store_sequencer_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  armleocpu_store_sequencer_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    logic [3:0]        mask;
  } entry_t;

  entry_t            mem_q [DEPTH];
  entry_t            mem_d [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [1:0]        state_q, state_d;
  logic              dbus_valid_q, dbus_valid_d;
  logic [ADDR_W-1:0] dbus_addr_q, dbus_addr_d;
  logic [31:0]       dbus_wdata_q, dbus_wdata_d;
  logic [3:0]        dbus_wmask_q, dbus_wmask_d;
  logic              rej_valid_q, rej_valid_d;
  logic [1:0]        rej_cause_q, rej_cause_d;
  logic              err_valid_q, err_valid_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;

  logic [31:0] gen_wdata;
  logic [3:0]  gen_wmask;
  logic [1:0]  gen_fault;
  logic        req_ready, accept, push, reject, pop;
  entry_t      head_e, next_e;

  armleocpu_storegen u_storegen (
    .addr_lo (bus.req_addr[1:0]),
    .st_type (bus.req_type),
    .st_data (bus.req_data),
    .wdata   (gen_wdata),
    .wmask   (gen_wmask),
    .fault   (gen_fault)
  );

  // Ready looks only at occupancy: a full buffer never accepts, even on a pop.
  assign req_ready = (count_q != FULL_CNT);
  assign accept    = bus.req_valid & req_ready;
  assign reject    = accept & (|gen_fault);
  assign push      = accept & ~(|gen_fault);
  assign head_e    = mem_q[head_q];
  assign next_e    = mem_q[head_q + PTR_W'(1)];

  always_comb begin
    mem_d       = mem_q;
    tail_d      = tail_q;
    head_d      = head_q;
    count_d     = count_q;
    rej_valid_d = reject;
    rej_cause_d = reject ? gen_fault : rej_cause_q;
    if (push) begin
      mem_d[tail_q] = '{addr: bus.req_addr, data: gen_wdata, mask: gen_wmask};
      tail_d        = tail_q + PTR_W'(1);
    end
    if (pop) begin
      head_d = head_q + PTR_W'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_comb begin
    state_d      = state_q;
    dbus_valid_d = dbus_valid_q;
    dbus_addr_d  = dbus_addr_q;
    dbus_wdata_d = dbus_wdata_q;
    dbus_wmask_d = dbus_wmask_q;
    err_valid_d  = 1'b0;
    err_addr_d   = err_addr_q;
    pop          = 1'b0;
    case (state_q)
      SEQ_IDLE: begin
        if (count_q != '0) begin
          state_d      = SEQ_ISSUE;
          dbus_valid_d = 1'b1;
          dbus_addr_d  = {head_e.addr[ADDR_W-1:2], 2'b00};
          dbus_wdata_d = head_e.data;
          dbus_wmask_d = head_e.mask;
        end
      end
      SEQ_ISSUE: begin
        if (bus.dbus_ready) begin
          state_d      = SEQ_WAIT;
          dbus_valid_d = 1'b0;
        end
      end
      SEQ_WAIT: begin
        if (bus.dbus_resp_valid) begin
          pop = 1'b1;
          if (bus.dbus_resp_error) begin
            err_valid_d = 1'b1;
            err_addr_d  = head_e.addr;
          end
          // Only entries already in the array are chained; a store pushed in
          // this same cycle is picked up through IDLE on the next cycle.
          if (count_q > CNT_W'(1)) begin
            state_d      = SEQ_ISSUE;
            dbus_valid_d = 1'b1;
            dbus_addr_d  = {next_e.addr[ADDR_W-1:2], 2'b00};
            dbus_wdata_d = next_e.data;
            dbus_wmask_d = next_e.mask;
          end else begin
            state_d = SEQ_IDLE;
          end
        end
      end
      default: begin
        state_d      = SEQ_IDLE;
        dbus_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      state_q      <= SEQ_IDLE;
      dbus_valid_q <= 1'b0;
      dbus_addr_q  <= '0;
      dbus_wdata_q <= '0;
      dbus_wmask_q <= '0;
      rej_valid_q  <= 1'b0;
      rej_cause_q  <= '0;
      err_valid_q  <= 1'b0;
      err_addr_q   <= '0;
    end else begin
      mem_q        <= mem_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      state_q      <= state_d;
      dbus_valid_q <= dbus_valid_d;
      dbus_addr_q  <= dbus_addr_d;
      dbus_wdata_q <= dbus_wdata_d;
      dbus_wmask_q <= dbus_wmask_d;
      rej_valid_q  <= rej_valid_d;
      rej_cause_q  <= rej_cause_d;
      err_valid_q  <= err_valid_d;
      err_addr_q   <= err_addr_d;
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.rej_valid  = rej_valid_q;
  assign bus.rej_cause  = rej_cause_q;
  assign bus.dbus_valid = dbus_valid_q;
  assign bus.dbus_addr  = dbus_addr_q;
  assign bus.dbus_wdata = dbus_wdata_q;
  assign bus.dbus_wmask = dbus_wmask_q;
  assign bus.err_valid  = err_valid_q;
  assign bus.err_addr   = err_addr_q;
  assign bus.empty      = (count_q == '0) && (state_q == SEQ_IDLE) && !rej_valid_q;
  assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_armleocpu_store_sequencer.sv
// Bench for the store sequencer: directed scenarios followed by random traffic,
// all checked against a byte-lane reference model and an expected-store queue.
module tb_armleocpu_store_sequencer;
  import armleocpu_store_sequencer_pkg::*;

  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  armleocpu_store_sequencer_if #(.ADDR_W(32)) bus ();

  armleocpu_store_sequencer #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Scoreboard: {byte addr, lane data, mask} of stores accepted but not issued.
  logic [67:0] exp_q[$];
  int          occ = 0;
  logic        model_wait = 1'b0;
  logic [31:0] wait_addr = '0;
  logic        exp_rej_now = 1'b0;
  logic [1:0]  exp_rej_cause = '0;
  logic        exp_err_now = 1'b0;
  logic [31:0] exp_err_addr = '0;

  logic        ready_en = 1'b0, rand_ready = 1'b0, resp_auto = 1'b1;
  logic        err_force = 1'b0, err_rand = 1'b0;
  int          gap_min = 1, gap_max = 1;
  logic        inflight = 1'b0;
  int          resp_cd = 0;

  logic        last_accept = 1'b0;
  int          hs_count = 0, err_seen = 0;
  logic [31:0] hs_addr = '0, hs_wdata = '0, last_err_addr = '0;
  logic [3:0]  hs_mask = '0;

  task automatic chk(input string tag, input logic [67:0] obs, input logic [67:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] model_fault(input logic [31:0] a, input logic [2:0] t);
    int size;
    if (t > 3'd2) return 2'b10;
    size = (t == 3'd0) ? 1 : (t == 3'd1) ? 2 : 4;
    if (a % size != 0) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [67:0] model_entry(input logic [31:0] a, input logic [2:0] t,
                                              input logic [31:0] d);
    int size, off, m;
    logic [63:0] keep, wd;
    size = (t == 3'd0) ? 1 : (t == 3'd1) ? 2 : 4;
    off  = int'(a % 4);
    keep = (64'd1 << (8 * size)) - 64'd1;
    wd   = ({32'd0, d} & keep) << (8 * off);
    m    = ((1 << size) - 1) << off;
    return {a, wd[31:0], m[3:0]};
  endfunction

  // One clock: check/observe mid-cycle, then drive the next cycle's inputs.
  task automatic step();
    logic [67:0] e;
    logic [1:0]  f;
    logic        nxt_rej, nxt_err, pushed;
    @(negedge clk);
    last_accept = 1'b0;
    if (!rst_n) begin
      exp_q.delete();
      occ = 0; model_wait = 1'b0; inflight = 1'b0;
      exp_rej_now = 1'b0; exp_err_now = 1'b0;
    end else begin
      chk("rej_valid", bus.rej_valid, exp_rej_now);
      if (exp_rej_now) chk("rej_cause", bus.rej_cause, exp_rej_cause);
      chk("err_valid", bus.err_valid, exp_err_now);
      if (exp_err_now) chk("err_addr", bus.err_addr, exp_err_addr);
      chk("req_ready", bus.req_ready, occ < DEPTH);
      chk("empty", bus.empty, (occ == 0) && !exp_rej_now);
      if (bus.err_valid) begin err_seen++; last_err_addr = bus.err_addr; end
      nxt_rej = 1'b0; nxt_err = 1'b0; pushed = 1'b0;
      if (bus.dbus_valid && bus.dbus_ready) begin
        chk("hs_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("dbus_addr", bus.dbus_addr, e[67:36] & 32'hFFFF_FFFC);
          chk("dbus_wdata", bus.dbus_wdata, e[35:4]);
          chk("dbus_wmask", bus.dbus_wmask, e[3:0]);
          wait_addr = e[67:36];
        end
        hs_count++; hs_addr = bus.dbus_addr; hs_wdata = bus.dbus_wdata; hs_mask = bus.dbus_wmask;
        model_wait = 1'b1; inflight = 1'b1;
        resp_cd = $urandom_range(gap_min, gap_max);
      end
      if (bus.req_valid && bus.req_ready) begin
        last_accept = 1'b1;
        f = model_fault(bus.req_addr, bus.req_type);
        if (f != 2'b00) begin
          nxt_rej = 1'b1; exp_rej_cause = f;
        end else begin
          exp_q.push_back(model_entry(bus.req_addr, bus.req_type, bus.req_data));
          pushed = 1'b1;
        end
      end
      if (bus.dbus_resp_valid && model_wait) begin
        model_wait = 1'b0; occ--;
        if (bus.dbus_resp_error) begin nxt_err = 1'b1; exp_err_addr = wait_addr; end
      end
      if (pushed) occ++;
      exp_rej_now = nxt_rej;
      exp_err_now = nxt_err;
    end
    @(posedge clk);
    #1;
    bus.dbus_ready = ready_en ? (rand_ready ? 1'($urandom_range(0, 1)) : 1'b1) : 1'b0;
    if (resp_auto) begin
      bus.dbus_resp_valid = 1'b0;
      bus.dbus_resp_error = 1'b0;
      if (inflight) begin
        if (resp_cd == 0) begin
          bus.dbus_resp_valid = 1'b1;
          bus.dbus_resp_error = err_force | (err_rand & ($urandom_range(0, 3) == 0));
          err_force = 1'b0;
          inflight  = 1'b0;
        end else begin
          resp_cd--;
        end
      end
    end
  endtask

  task automatic send_req(input logic [31:0] a, input logic [2:0] t, input logic [31:0] d);
    int guard = 0;
    bus.req_valid = 1'b1; bus.req_addr = a; bus.req_type = t; bus.req_data = d;
    do begin step(); guard++; end while (!last_accept && guard < 200);
    chk("req_accept_timeout", last_accept, 1'b1);
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while ((occ != 0 || model_wait || inflight || exp_rej_now || exp_err_now) && guard < 500) begin
      step(); guard++;
    end
    chk("drain_timeout", guard < 500, 1'b1);
    step();
  endtask

  initial begin
    int hs0, err0, guard;
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_type = '0; bus.req_data = '0;
    bus.dbus_ready = 1'b0; bus.dbus_resp_valid = 1'b0; bus.dbus_resp_error = 1'b0;

    // Reset state
    repeat (3) step();
    rst_n = 1'b1;
    chk("rst_dbus_valid", bus.dbus_valid, 1'b0);
    chk("rst_rej_valid", bus.rej_valid, 1'b0);
    chk("rst_err_valid", bus.err_valid, 1'b0);
    chk("rst_rej_cause", bus.rej_cause, 2'b00);
    chk("rst_err_addr", bus.err_addr, 32'd0);
    chk("rst_dbus_addr", bus.dbus_addr, 32'd0);
    chk("rst_dbus_wdata", bus.dbus_wdata, 32'd0);
    chk("rst_dbus_wmask", bus.dbus_wmask, 4'd0);
    chk("rst_empty", bus.empty, 1'b1);
    chk("rst_req_ready", bus.req_ready, 1'b1);
    chk("rst_state", bus.dbg_state, SEQ_IDLE);
    step();

    // WORD store, ready held high, response two cycles after the handshake
    ready_en = 1'b1; gap_min = 1; gap_max = 1;
    send_req(32'h1000, STORE_WORD, 32'hDEAD_BEEF);
    chk("lat_n1_dbus_valid", bus.dbus_valid, 1'b0);
    step();
    chk("lat_n2_dbus_valid", bus.dbus_valid, 1'b1);
    chk("lat_n2_state", bus.dbg_state, SEQ_ISSUE);
    chk("word_addr", bus.dbus_addr, 32'h1000);
    chk("word_wdata", bus.dbus_wdata, 32'hDEAD_BEEF);
    chk("word_wmask", bus.dbus_wmask, 4'b1111);
    drain();
    chk("word_empty", bus.empty, 1'b1);

    // BYTE store into the top lane
    send_req(32'h2003, STORE_BYTE, 32'h0000_00AB);
    drain();
    chk("byte_addr", hs_addr, 32'h2000);
    chk("byte_wdata", hs_wdata, 32'hAB00_0000);
    chk("byte_wmask", hs_mask, 4'b1000);

    // Rejects: misaligned HALF, then unknown type
    hs0 = hs_count;
    send_req(32'h3001, STORE_HALF, 32'h1234_5678);
    chk("rej_mis_valid", bus.rej_valid, 1'b1);
    chk("rej_mis_cause", bus.rej_cause, 2'b01);
    chk("rej_mis_dbus_valid", bus.dbus_valid, 1'b0);
    step();
    chk("rej_pulse_end", bus.rej_valid, 1'b0);
    chk("rej_empty", bus.empty, 1'b1);
    send_req(32'h3000, 3'b011, 32'h1234_5678);
    chk("rej_type_cause", bus.rej_cause, 2'b10);
    drain();
    chk("rej_no_issue", hs_count, hs0);
    chk("rej_empty_after", bus.empty, 1'b1);

    // Three back-to-back stores with the bus stalled
    hs0 = hs_count;
    ready_en = 1'b0;
    send_req(32'h0000_0100, STORE_WORD, 32'h1111_1111);
    send_req(32'h0000_0206, STORE_HALF, 32'h0000_2222);
    chk("full_req_ready", bus.req_ready, 1'b0);
    ready_en = 1'b1;
    send_req(32'h0000_0301, STORE_BYTE, 32'h0000_0033);
    drain();
    chk("b2b_issue_count", hs_count, hs0 + 3);
    chk("b2b_last_addr", hs_addr, 32'h0000_0300);

    // Bus error on the HALF store; the following store still goes out
    hs0 = hs_count; err0 = err_seen;
    ready_en = 1'b0;
    send_req(32'h4002, STORE_HALF, 32'h0000_BEEF);
    send_req(32'h5000, STORE_WORD, 32'hCAFE_F00D);
    err_force = 1'b1; ready_en = 1'b1;
    drain();
    chk("err_pulse_count", err_seen, err0 + 1);
    chk("err_addr_val", last_err_addr, 32'h4002);
    chk("err_next_issued", hs_count, hs0 + 2);
    chk("err_next_addr", hs_addr, 32'h5000);

    // Reset while waiting for a response with one more store buffered
    resp_auto = 1'b0; ready_en = 1'b0;
    send_req(32'h6000, STORE_WORD, 32'h6666_6666);
    send_req(32'h7000, STORE_WORD, 32'h7777_7777);
    ready_en = 1'b1;
    guard = 0;
    while (!model_wait && guard < 50) begin step(); guard++; end
    chk("rst_wait_reached", model_wait, 1'b1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("midrst_dbus_valid", bus.dbus_valid, 1'b0);
    chk("midrst_empty", bus.empty, 1'b1);
    err0 = err_seen;
    bus.dbus_resp_valid = 1'b1; bus.dbus_resp_error = 1'b1;
    step();
    bus.dbus_resp_valid = 1'b0; bus.dbus_resp_error = 1'b0;
    chk("late_resp_no_err", bus.err_valid, 1'b0);
    chk("late_resp_dbus_valid", bus.dbus_valid, 1'b0);
    repeat (3) step();
    chk("late_resp_err_count", err_seen, err0);
    resp_auto = 1'b1;

    // Random traffic
    rand_ready = 1'b1; err_rand = 1'b1; gap_min = 1; gap_max = 3;
    for (int k = 0; k < 150; k++) begin
      logic [2:0] t;
      t = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
      send_req($urandom, t, $urandom);
      repeat ($urandom_range(0, 2)) step();
    end
    drain();
    chk("rand_queue_drained", exp_q.size(), 0);
    chk("rand_empty", bus.empty, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
